// File: rtl/bcd_comp_seq.sv
// Digit-serial N-digit BCD 9's/10's complementer. It handles one digit per clock,
// least significant digit first, and uses a start/busy/done handshake.
module bcd_comp_seq #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           mode,
  input  logic [4*N-1:0] din,
  output logic           busy,
  output logic           done,
  output logic [4*N-1:0] dout,
  output logic           err,
  output logic           cout
);

  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state, state_nxt;
  logic [KW-1:0]  k;
  logic [4*N-1:0] opnd, wres, wres_nxt;
  logic           c, werr;
  logic [3:0]     dig;
  logic           dig_c, dig_e;
  logic           last, accept;

  // Returns {invalid, carry_out, result_digit} for one operand digit.
  function automatic logic [5:0] comp_digit(input logic [3:0] d, input logic ci);
    logic [4:0] s;
    if (d > 4'd9) begin
      comp_digit = {1'b1, 1'b0, 4'd0};
    end else begin
      s = {1'b0, 4'd9 - d} + {4'd0, ci};
      if (s == 5'd10) comp_digit = {1'b0, 1'b1, 4'd0};
      else            comp_digit = {1'b0, 1'b0, s[3:0]};
    end
  endfunction

  assign {dig_e, dig_c, dig} = comp_digit(opnd[3:0], c);
  assign last   = (k == KW'(N - 1));
  assign accept = start && (state != RUN);
  assign busy   = (state == RUN);
  assign done   = (state == DONE);

  // The operand shifts right and result digits enter from the top, so digit k lands at position k after N steps.
  if (N == 1) begin : g_one
    assign wres_nxt = dig;
  end else begin : g_many
    assign wres_nxt = {dig, wres[4*N-1:4]};
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      k     <= '0;
      c     <= 1'b0;
      werr  <= 1'b0;
      dout  <= '0;
      err   <= 1'b0;
      cout  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        opnd <= din;
        k    <= '0;
        c    <= ~mode;
        werr <= 1'b0;
      end else if (state == RUN) begin
        opnd <= opnd >> 4;
        wres <= wres_nxt;
        k    <= k + 1'b1;
        c    <= dig_c;
        werr <= werr | dig_e;
        if (last) begin
          dout <= wres_nxt;
          err  <= werr | dig_e;
          cout <= dig_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_comp_seq.sv
// Scoreboard bench for bcd_comp_seq (N=4). The stimulus side queues expected results,
// and a monitor compares them against the DUT outputs on every done pulse.
module tb_bcd_comp_seq;

  localparam int N = 4;

  typedef struct {
    logic [4*N-1:0] dout;
    logic           err;
    logic           cout;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst, start, mode;
  logic [4*N-1:0] din;
  logic           busy, done, err, cout;
  logic [4*N-1:0] dout;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;

  bcd_comp_seq #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .din(din),
    .busy(busy), .done(done), .dout(dout), .err(err), .cout(cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("dout", 32'(dout), 32'(e.dout));
        chk("err",  32'(err),  32'(e.err));
        chk("cout", 32'(cout), 32'(e.cout));
      end
    end
  end

  // The caller is positioned just after a rising edge. This task issues a one-cycle start
  // and checks the busy/done timing cycle by cycle.
  task automatic run_op(input logic m, input logic [4*N-1:0] d,
                        input logic [4*N-1:0] ed, input logic ee, input logic ec);
    start = 1'b1; mode = m; din = d;
    sb.push_back('{dout: ed, err: ee, cout: ec});
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < N; i++) begin
      chk("busy_run", 32'(busy), 32'd1);
      chk("done_early", 32'(done), 32'd0);
      @(posedge clk); #1;
    end
    chk("busy_after", 32'(busy), 32'd0);
    chk("done_pulse", 32'(done), 32'd1);
    @(posedge clk); #1;
    chk("done_one_cycle", 32'(done), 32'd0);
  endtask

  typedef struct {
    logic           m;
    logic [4*N-1:0] d;
    logic [4*N-1:0] ed;
    logic           ee;
    logic           ec;
  } vec_t;

  vec_t dir_vecs[$] = '{
    '{1'b0, 16'h1234, 16'h8766, 1'b0, 1'b0},
    '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1},
    '{1'b0, 16'h0900, 16'h9100, 1'b0, 1'b0},
    '{1'b1, 16'h1234, 16'h8765, 1'b0, 1'b0},
    '{1'b1, 16'h9999, 16'h0000, 1'b0, 1'b0},
    '{1'b0, 16'h12A4, 16'h8706, 1'b1, 1'b0},
    '{1'b0, 16'h0001, 16'h9999, 1'b0, 1'b0}
  };

  vec_t held_vecs[$] = '{
    '{1'b0, 16'h0050, 16'h9950, 1'b0, 1'b0},
    '{1'b0, 16'h9999, 16'h0001, 1'b0, 1'b0},
    '{1'b1, 16'h4321, 16'h5678, 1'b0, 1'b0}
  };

  initial begin
    rst = 1'b1; start = 1'b0; mode = 1'b0; din = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_err",  32'(err),  32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (dir_vecs[i])
      run_op(dir_vecs[i].m, dir_vecs[i].d, dir_vecs[i].ed, dir_vecs[i].ee, dir_vecs[i].ec);

    // A second start arriving while the block is in RUN must be ignored.
    start = 1'b1; mode = 1'b0; din = 16'h1234;
    sb.push_back('{dout: 16'h8766, err: 1'b0, cout: 1'b0});
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; mode = 1'b1; din = 16'h5555;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("ignored_start_dout", 32'(dout), 32'h8766);

    // While start is held high, a new operation is accepted in every DONE cycle.
    start = 1'b1;
    foreach (held_vecs[i]) begin
      mode = held_vecs[i].m; din = held_vecs[i].d;
      sb.push_back('{dout: held_vecs[i].ed, err: held_vecs[i].ee, cout: held_vecs[i].ec});
      @(posedge clk); #1;
      chk("held_busy", 32'(busy), 32'd1);
      repeat (N) @(posedge clk);
      #1;
      chk("held_done", 32'(done), 32'd1);
    end
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Reset in the second RUN cycle aborts the operation without a done pulse.
    start = 1'b1; mode = 1'b0; din = 16'h0123;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_dout", 32'(dout), 32'd0);
    chk("abort_err",  32'(err),  32'd0);
    chk("abort_cout", 32'(cout), 32'd0);
    repeat (6) @(posedge clk);
    #1;
    chk("abort_no_done", 32'(done), 32'd0);
    run_op(1'b0, 16'h0123, 16'h9877, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
